mnist_test_sequencer: RTL

Parametrised on-FPGA regression sequencer for the LGN MNIST core. It streams each test image byte by byte from a synchronous pattern ROM into the DUT and waits a fixed settle time. It then samples the DUT's class index and score and compares the index against the expected label. Unlike the fixed board harness, it counts every mismatch, records the first failing image, and can either halt on the first failure or run to completion. It sits between the board top level (ROM, buttons, LEDs, seven-segment) and `tt_um_rejunity_lgn_mnist`.

---
 rtl/mnist_test_sequencer.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/mnist_test_sequencer.sv
// mnist_test_sequencer: on-FPGA regression sequencer for the LGN MNIST core.
// For each image it streams bytes from a synchronous pattern ROM into the DUT,
// waits a settle time, samples the DUT class index and score, and compares the
// index with the expected label. It counts mismatches, records the first failing
// image, and optionally halts on the first failure.
// Optional feature macro: SEQ_LABEL_ROM_EN (expected labels from a label ROM
// instead of the modulo-NUM_CLASSES counter).
module mnist_test_sequencer #(
  parameter int IMAGE_COUNT     = 480,
  parameter int BYTES_PER_IMAGE = 32,
  parameter int DATA_W          = 8,
  parameter int LABEL_W         = 4,
  parameter int VALUE_W         = 8,
  parameter int NUM_CLASSES     = 10,
  parameter int SETTLE_CYCLES   = 2,
  parameter int ADDR_W          = $clog2(IMAGE_COUNT*BYTES_PER_IMAGE),
  parameter int IDX_W           = $clog2(IMAGE_COUNT+1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               step,
  input  logic               halt_on_fail,
  output logic [ADDR_W-1:0]  rom_addr,
  input  logic [DATA_W-1:0]  rom_data,
  output logic [DATA_W-1:0]  dut_data,
  output logic               dut_valid,
  input  logic [LABEL_W-1:0] dut_index,
  input  logic [VALUE_W-1:0] dut_value,
`ifdef SEQ_LABEL_ROM_EN
  output logic [IDX_W-1:0]   label_addr,
  input  logic [LABEL_W-1:0] label_data,
`endif
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic               fail,
  output logic [IDX_W-1:0]   image_idx,
  output logic [LABEL_W-1:0] expected_label,
  output logic [LABEL_W-1:0] result_index,
  output logic [VALUE_W-1:0] result_value,
  output logic [IDX_W-1:0]   error_count,
  output logic [IDX_W-1:0]   first_fail_idx
);

  localparam int BW = (BYTES_PER_IMAGE > 1) ? $clog2(BYTES_PER_IMAGE) : 1;
  // Shared phase counter must reach BYTES_PER_IMAGE+1 (LOAD) and SETTLE_CYCLES-1.
  localparam int CW = $clog2(BYTES_PER_IMAGE + SETTLE_CYCLES + 2) + 1;

  localparam logic [CW-1:0]      BPI_C       = CW'(BYTES_PER_IMAGE);
  localparam logic [CW-1:0]      LOAD_LAST   = CW'(BYTES_PER_IMAGE + 1);
  localparam logic [CW-1:0]      SETTLE_LAST = CW'(SETTLE_CYCLES - 1);
  localparam logic [IDX_W-1:0]   LAST_IDX    = IDX_W'(IMAGE_COUNT - 1);
  localparam logic [IDX_W-1:0]   ERR_MAX     = IDX_W'(IMAGE_COUNT);
  localparam logic [IDX_W-1:0]   IDX_ONES    = '1;
  localparam logic [LABEL_W-1:0] LABEL_LAST  = LABEL_W'(NUM_CLASSES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT, S_LOAD, S_SETTLE, S_CHECK, S_DONE
  } state_t;

  state_t             state_q;
  logic [CW-1:0]      cnt_q;
  logic               halt_q;
  logic [IDX_W-1:0]   image_idx_q;
  logic [LABEL_W-1:0] expected_label_q;
  logic [LABEL_W-1:0] result_index_q;
  logic [VALUE_W-1:0] result_value_q;
  logic [IDX_W-1:0]   error_count_q;
  logic [IDX_W-1:0]   first_fail_q;
  logic               fail_q;
  logic [1:0]         vld_pipe_q;   // [0]: ROM read in flight, [1]: byte on dut_data
  logic [DATA_W-1:0]  dut_data_q;

  logic               rd_vld_d;
  logic               mismatch_d;
  logic [IDX_W-1:0]   err_inc_d;
  logic [ADDR_W-1:0]  addr_d;

  // A ROM read is issued in the first BYTES_PER_IMAGE LOAD cycles; the other two drain the pipe.
  assign rd_vld_d   = (state_q == S_LOAD) && (cnt_q < BPI_C);
  assign mismatch_d = (dut_index != expected_label_q);
  assign err_inc_d  = (error_count_q == ERR_MAX) ? ERR_MAX : error_count_q + 1'b1;

  generate
    if (BYTES_PER_IMAGE == 1) begin : g_addr1
      assign addr_d = ADDR_W'(image_idx_q);
    end else begin : g_addrn
      assign addr_d = ADDR_W'({image_idx_q, cnt_q[BW-1:0]});
    end
  endgenerate

  assign rom_addr = rd_vld_d ? addr_d : '0;

  // Two-stage byte pipeline: ROM latency, then the registered DUT input byte.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe_q <= '0;
      dut_data_q <= '0;
    end else begin
      vld_pipe_q <= {vld_pipe_q[0], rd_vld_d};
      dut_data_q <= vld_pipe_q[0] ? rom_data : '0;
    end
  end

  // Main sequencer FSM with all run bookkeeping registered alongside the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= S_IDLE;
      cnt_q            <= '0;
      halt_q           <= 1'b0;
      image_idx_q      <= '0;
      expected_label_q <= '0;
      result_index_q   <= '0;
      result_value_q   <= '0;
      error_count_q    <= '0;
      first_fail_q     <= IDX_ONES;
      fail_q           <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            state_q          <= S_WAIT;
            cnt_q            <= '0;
            halt_q           <= halt_on_fail;
            image_idx_q      <= '0;
            expected_label_q <= '0;
            result_index_q   <= '0;
            result_value_q   <= '0;
            error_count_q    <= '0;
            first_fail_q     <= IDX_ONES;
            fail_q           <= 1'b0;
          end
        end
        S_WAIT: begin
          if (step) begin
            state_q <= S_LOAD;
            cnt_q   <= '0;
          end
        end
        S_LOAD: begin
`ifdef SEQ_LABEL_ROM_EN
          // label_addr has been stable since WAIT, so label_data is valid throughout LOAD.
          expected_label_q <= label_data;
`endif
          if (cnt_q == LOAD_LAST) begin
            cnt_q   <= '0;
            state_q <= S_SETTLE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_SETTLE: begin
          if (cnt_q == SETTLE_LAST) begin
            cnt_q   <= '0;
            state_q <= S_CHECK;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_CHECK: begin
          result_index_q <= dut_index;
          result_value_q <= dut_value;
          if (mismatch_d) begin
            error_count_q <= err_inc_d;
            fail_q        <= 1'b1;
            if (error_count_q == '0) first_fail_q <= image_idx_q;
          end
          if (mismatch_d && halt_q) begin
            state_q <= S_DONE;
          end else if (image_idx_q == LAST_IDX) begin
            state_q <= S_DONE;
          end else begin
            image_idx_q <= image_idx_q + 1'b1;
`ifndef SEQ_LABEL_ROM_EN
            expected_label_q <= (expected_label_q == LABEL_LAST) ? '0 : expected_label_q + 1'b1;
`endif
            state_q <= S_WAIT;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

`ifdef SEQ_LABEL_ROM_EN
  assign label_addr = image_idx_q;
`endif

  assign dut_data       = dut_data_q;
  assign dut_valid      = vld_pipe_q[1];
  assign busy           = (state_q != S_IDLE) && (state_q != S_DONE);
  assign done           = (state_q == S_DONE);
  assign pass           = done && (error_count_q == '0);
  assign fail           = fail_q;
  assign image_idx      = image_idx_q;
  assign expected_label = expected_label_q;
  assign result_index   = result_index_q;
  assign result_value   = result_value_q;
  assign error_count    = error_count_q;
  assign first_fail_idx = first_fail_q;

endmodule
